// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// exception codes and the legality check used at request capture.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } lsu_state_e;

  localparam logic [1:0] EXC_NONE        = 2'b00;
  localparam logic [1:0] EXC_LD_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_ST_MISALIGN = 2'b10;
  localparam logic [1:0] EXC_WIDTH       = 2'b11;

  // Width problems take priority over misalignment.
  function automatic logic [1:0] lsu_check(input logic we, input logic [2:0] funct3,
                                           input logic [2:0] addr_lo, input logic is64);
    logic unsupported;
    logic misaligned;
    unsupported = (funct3 == 3'b111) || (we && funct3[2]) ||
                  (!is64 && (funct3 == F3_D || funct3 == F3_WU));
    case (funct3[1:0])
      2'b01:   misaligned = addr_lo[0];
      2'b10:   misaligned = (addr_lo[1:0] != 2'b00);
      2'b11:   misaligned = (addr_lo != 3'b000);
      default: misaligned = 1'b0;
    endcase
    if (unsupported) return EXC_WIDTH;
    if (misaligned) return we ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
    return EXC_NONE;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables and data placement, and
// load data extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]                  st_size_i,
  input  logic [$clog2(XLEN/8)-1:0]   st_off_i,
  input  logic [XLEN-1:0]             st_wdata_i,
  output logic [XLEN/8-1:0]           st_be_o,
  output logic [XLEN-1:0]             st_wdata_o,
  input  logic [2:0]                  ld_funct3_i,
  input  logic [$clog2(XLEN/8)-1:0]   ld_off_i,
  input  logic [XLEN-1:0]             ld_rdata_i,
  output logic [XLEN-1:0]             ld_data_o
);

  localparam int NB = XLEN / 8;

  logic [NB-1:0]   width_mask;
  logic [XLEN-1:0] lane_mask;
  logic [XLEN-1:0] ld_shifted;

  always_comb begin
    case (st_size_i)
      2'b00:   width_mask = NB'(1);
      2'b01:   width_mask = NB'(3);
      2'b10:   width_mask = NB'(15);
      default: width_mask = '1;
    endcase
  end

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign lane_mask[8*gi +: 8] = {8{width_mask[gi]}};
  end

  assign st_be_o    = width_mask << st_off_i;
  assign st_wdata_o = (st_wdata_i & lane_mask) << {st_off_i, 3'b000};

  assign ld_shifted = ld_rdata_i >> {ld_off_i, 3'b000};

  always_comb begin
    case (ld_funct3_i)
      F3_B:    ld_data_o = XLEN'($signed(ld_shifted[7:0]));
      F3_H:    ld_data_o = XLEN'($signed(ld_shifted[15:0]));
      F3_W:    ld_data_o = XLEN'($signed(ld_shifted[31:0]));
      F3_BU:   ld_data_o = XLEN'(ld_shifted[7:0]);
      F3_HU:   ld_data_o = XLEN'(ld_shifted[15:0]);
      F3_WU:   ld_data_o = XLEN'(ld_shifted[31:0]);
      default: ld_data_o = ld_shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// M-stage load/store unit: captures one memory op, runs a req/gnt/rvalid
// handshake, and returns aligned load data or a registered exception pulse.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  input  logic [4:0]          req_rd,
  input  logic                kill,
  output logic                stall,
  output logic                wb_valid,
  output logic [4:0]          wb_rd,
  output logic [XLEN-1:0]     wb_data,
  output logic                exc_valid,
  output logic [1:0]          exc_code,
  output logic                mem_req,
  input  logic                mem_gnt,
  output logic                mem_we,
  output logic [XLEN/8-1:0]   mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic                mem_rvalid,
  input  logic [XLEN-1:0]     mem_rdata
);

  localparam int   NB    = XLEN / 8;
  localparam int   OFF_W = $clog2(NB);
  localparam logic IS64  = (XLEN == 64);

  lsu_state_e        state_q;
  logic              drop_q;
  logic              is_load_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [NB-1:0]     mem_be_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [XLEN-1:0]   mem_wdata_q;
  logic [2:0]        ld_funct3_q;
  logic [OFF_W-1:0]  ld_off_q;
  logic [4:0]        rd_q;
  logic              wb_valid_q;
  logic [4:0]        wb_rd_q;
  logic [XLEN-1:0]   wb_data_q;
  logic              exc_valid_q;
  logic [1:0]        exc_code_q;

  logic [1:0]        chk_code;
  logic              legal;
  logic              accept;
  logic [NB-1:0]     st_be;
  logic [XLEN-1:0]   st_wdata;
  logic [XLEN-1:0]   ld_data;

  assign chk_code = lsu_check(req_we, req_funct3, req_addr[2:0], IS64);
  assign legal    = (chk_code == EXC_NONE);
  assign accept   = (state_q == ST_IDLE) && req_valid && !kill && legal;

  // Upstream may advance in the same cycle the response lands.
  assign stall = (state_q == ST_IDLE) ? accept : !(state_q == ST_WAIT && mem_rvalid);

  lsu_align #(.XLEN(XLEN)) u_align (
    .st_size_i   (req_funct3[1:0]),
    .st_off_i    (req_addr[OFF_W-1:0]),
    .st_wdata_i  (req_wdata),
    .st_be_o     (st_be),
    .st_wdata_o  (st_wdata),
    .ld_funct3_i (ld_funct3_q),
    .ld_off_i    (ld_off_q),
    .ld_rdata_i  (mem_rdata),
    .ld_data_o   (ld_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      drop_q      <= 1'b0;
      is_load_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ld_funct3_q <= '0;
      ld_off_q    <= '0;
      rd_q        <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      exc_valid_q <= 1'b0;
      exc_code_q  <= '0;
    end else begin
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      exc_valid_q <= 1'b0;
      exc_code_q  <= '0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid && !kill && !legal) begin
            exc_valid_q <= 1'b1;
            exc_code_q  <= chk_code;
          end
          if (accept) begin
            state_q     <= ST_REQ;
            drop_q      <= 1'b0;
            is_load_q   <= !req_we;
            mem_req_q   <= 1'b1;
            mem_we_q    <= req_we;
            mem_be_q    <= st_be;
            mem_addr_q  <= {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
            mem_wdata_q <= req_we ? st_wdata : '0;
            ld_funct3_q <= req_funct3;
            ld_off_q    <= req_addr[OFF_W-1:0];
            rd_q        <= req_rd;
          end
        end
        ST_REQ: begin
          if (mem_gnt || kill) begin
            state_q     <= mem_gnt ? ST_WAIT : ST_IDLE;
            drop_q      <= kill;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            state_q <= ST_IDLE;
            drop_q  <= 1'b0;
            if (is_load_q && !drop_q && !kill) begin
              wb_valid_q <= 1'b1;
              wb_rd_q    <= rd_q;
              wb_data_q  <= ld_data;
            end
          end else if (kill) begin
            drop_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign exc_valid = exc_valid_q;
  assign exc_code  = exc_code_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a 32-bit instance checked every cycle
// against an arithmetic model, plus a 64-bit instance for the wide-only ops.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 32-bit DUT
  logic        req_valid, req_we, kill, mem_gnt, mem_rvalid;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, mem_rdata;
  logic [4:0]  req_rd;
  logic        stall, wb_valid, exc_valid, mem_req, mem_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, mem_addr, mem_wdata;
  logic [1:0]  exc_code;
  logic [3:0]  mem_be;

  // 64-bit DUT
  logic        x_req_valid, x_req_we, x_kill, x_mem_gnt, x_mem_rvalid;
  logic [2:0]  x_req_funct3;
  logic [31:0] x_req_addr, x_mem_addr;
  logic [63:0] x_req_wdata, x_mem_rdata, x_wb_data, x_mem_wdata;
  logic [4:0]  x_req_rd, x_wb_rd;
  logic        x_stall, x_wb_valid, x_exc_valid, x_mem_req, x_mem_we;
  logic [1:0]  x_exc_code;
  logic [7:0]  x_mem_be;

  load_store_unit #(.XLEN(32), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .kill(kill), .stall(stall), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .exc_valid(exc_valid), .exc_code(exc_code),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  load_store_unit #(.XLEN(64), .ADDR_W(32)) dut64 (
    .clk(clk), .reset(reset), .req_valid(x_req_valid), .req_we(x_req_we),
    .req_funct3(x_req_funct3), .req_addr(x_req_addr), .req_wdata(x_req_wdata),
    .req_rd(x_req_rd), .kill(x_kill), .stall(x_stall), .wb_valid(x_wb_valid),
    .wb_rd(x_wb_rd), .wb_data(x_wb_data), .exc_valid(x_exc_valid), .exc_code(x_exc_code),
    .mem_req(x_mem_req), .mem_gnt(x_mem_gnt), .mem_we(x_mem_we), .mem_be(x_mem_be),
    .mem_addr(x_mem_addr), .mem_wdata(x_mem_wdata), .mem_rvalid(x_mem_rvalid),
    .mem_rdata(x_mem_rdata)
  );

  int errors = 0;
  int checks = 0;

  logic        cmp_en;
  logic        exp_stall, exp_req, exp_we, exp_wb_valid, exp_exc_valid;
  logic [3:0]  exp_be;
  logic [31:0] exp_addr, exp_wdata, exp_wb_data;
  logic [4:0]  exp_wb_rd;
  logic [1:0]  exp_exc_code;

  logic [3:0]  last_be;
  logic [31:0] last_addr, last_wdata, last_wb;
  logic [1:0]  last_exc;
  int          wb_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model (XLEN = 32) ----------------
  function automatic logic [1:0] m_exc(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int size;
    size = 1 << f3[1:0];
    if (f3 == 3'b111 || f3 == 3'b011 || f3 == 3'b110 || (we && f3 >= 3'b011)) return 2'b11;
    if ((a % size) != 0) return we ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int size;
    size = 1 << f3[1:0];
    return 4'(((1 << size) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    logic [63:0] v;
    int size;
    size = 1 << f3[1:0];
    v = 64'(wd) & ((64'd1 << (8 * size)) - 64'd1);
    v = v << (8 * (a % 4));
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [63:0] v, mask;
    int size;
    size = 1 << f3[1:0];
    v = 64'(rd) >> (8 * (a % 4));
    mask = (64'd1 << (8 * size)) - 64'd1;
    v = v & mask;
    if (!f3[2] && v[8 * size - 1]) v = v | ~mask;
    return v[31:0];
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("stall", 64'(stall), 64'(exp_stall));
      chk("mem_req", 64'(mem_req), 64'(exp_req));
      if (exp_req) begin
        chk("mem_we", 64'(mem_we), 64'(exp_we));
        chk("mem_be", 64'(mem_be), 64'(exp_be));
        chk("mem_addr", 64'(mem_addr), 64'(exp_addr));
        chk("mem_wdata", 64'(mem_wdata), 64'(exp_wdata));
      end
      if (mem_req) begin
        last_be = mem_be; last_addr = mem_addr; last_wdata = mem_wdata;
      end
      chk("wb_valid", 64'(wb_valid), 64'(exp_wb_valid));
      if (exp_wb_valid) begin
        chk("wb_rd", 64'(wb_rd), 64'(exp_wb_rd));
        chk("wb_data", 64'(wb_data), 64'(exp_wb_data));
      end
      if (wb_valid) begin
        last_wb = wb_data; wb_cnt++;
      end
      chk("exc_valid", 64'(exc_valid), 64'(exp_exc_valid));
      if (exp_exc_valid) chk("exc_code", 64'(exc_code), 64'(exp_exc_code));
      if (exc_valid) last_exc = exc_code;
    end
  end

  // kill_at: 0 none, 1 in REQ without grant, 2 in first WAIT cycle,
  //          3 in IDLE while presented, 4 together with the grant
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] rdata,
                        input int gwait, input int rwait, input int kill_at);
    logic [1:0] code;
    logic dropped;
    code = m_exc(we, f3, addr);
    $display("op we=%0d f3=%0d addr=%h wdata=%h rd=%0d rdata=%h gwait=%0d rwait=%0d kill=%0d exp_exc=%0d",
             we, f3, addr, wd, rd, rdata, gwait, rwait, kill_at, code);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_rd = rd;
    kill = (kill_at == 3);
    exp_stall = (code == 2'b00) && (kill_at != 3);
    if (code != 2'b00 || kill_at == 3) begin
      @(posedge clk); #1;
      req_valid = 1'b0; kill = 1'b0; exp_stall = 1'b0;
      exp_exc_valid = (code != 2'b00) && (kill_at != 3);
      exp_exc_code = code;
      @(posedge clk); #1;
      exp_exc_valid = 1'b0;
      return;
    end
    exp_we = we; exp_be = m_be(f3, addr); exp_addr = {addr[31:2], 2'b00};
    exp_wdata = we ? m_wdata(f3, addr, wd) : 32'h0;
    @(posedge clk); #1;
    exp_req = 1'b1;
    for (int i = 0; i < gwait; i++) begin
      mem_rvalid = (i == 1); mem_rdata = 32'h5A5A5A5A;
      if (kill_at == 1) begin
        kill = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1;
        kill = 1'b0; mem_rvalid = 1'b0; exp_req = 1'b0; exp_stall = 1'b0;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b0;
    mem_gnt = 1'b1; kill = (kill_at == 4);
    dropped = (kill_at == 4) || (kill_at == 2);
    @(posedge clk); #1;
    mem_gnt = 1'b0; kill = 1'b0; exp_req = 1'b0;
    for (int i = 0; i < rwait; i++) begin
      kill = (kill_at == 2 && i == 0);
      @(posedge clk); #1;
    end
    kill = (kill_at == 2 && rwait == 0);
    mem_rvalid = 1'b1; mem_rdata = rdata; exp_stall = 1'b0;
    @(posedge clk); #1;
    mem_rvalid = 1'b0; kill = 1'b0; req_valid = 1'b0;
    exp_wb_valid = !we && !dropped; exp_wb_rd = rd; exp_wb_data = m_load(f3, addr, rdata);
    @(posedge clk); #1;
    exp_wb_valid = 1'b0;
  endtask

  initial begin
    int wb_before;
    reset = 1'b1; cmp_en = 1'b0;
    req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0; req_rd = 0;
    kill = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    x_req_valid = 0; x_req_we = 0; x_req_funct3 = 0; x_req_addr = 0; x_req_wdata = 0; x_req_rd = 0;
    x_kill = 0; x_mem_gnt = 0; x_mem_rvalid = 0; x_mem_rdata = 0;
    exp_stall = 0; exp_req = 0; exp_we = 0; exp_wb_valid = 0; exp_exc_valid = 0;
    exp_be = 0; exp_addr = 0; exp_wdata = 0; exp_wb_data = 0; exp_wb_rd = 0; exp_exc_code = 0;
    last_be = 0; last_addr = 0; last_wdata = 0; last_wb = 0; last_exc = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", 64'(stall), 64'h0);
    chk("rst_mem_req", 64'(mem_req), 64'h0);
    chk("rst_mem_be", 64'(mem_be), 64'h0);
    chk("rst_mem_addr", 64'(mem_addr), 64'h0);
    chk("rst_wb_valid", 64'(wb_valid), 64'h0);
    chk("rst_wb_data", 64'(wb_data), 64'h0);
    chk("rst_exc_valid", 64'(exc_valid), 64'h0);
    chk("rst_x_mem_req", 64'(x_mem_req), 64'h0);
    reset = 1'b0; cmp_en = 1'b1;
    @(posedge clk); #1;

    run_op(1'b1, 3'b000, 32'h103, 32'hAB, 5'd0, 32'h0, 0, 0, 0);
    chk("sb_be_lit", 64'(last_be), 64'h8);
    chk("sb_addr_lit", 64'(last_addr), 64'h100);
    chk("sb_wdata_lit", 64'(last_wdata), 64'hAB000000);

    run_op(1'b0, 3'b001, 32'h202, 32'h0, 5'd3, 32'h80011234, 1, 2, 0);
    chk("lh_wb_lit", 64'(last_wb), 64'hFFFF8001);

    run_op(1'b0, 3'b010, 32'h301, 32'h0, 5'd4, 32'h0, 0, 0, 0);
    chk("lw_mis_lit", 64'(last_exc), 64'h1);

    wb_before = wb_cnt;
    run_op(1'b0, 3'b010, 32'h300, 32'h0, 5'd4, 32'h11111111, 0, 2, 2);
    chk("kill_wait_no_wb", 64'(wb_cnt), 64'(wb_before));

    run_op(1'b0, 3'b010, 32'h304, 32'h0, 5'd5, 32'hDEADBEEF, 0, 0, 0);
    chk("lw_wb_lit", 64'(last_wb), 64'hDEADBEEF);

    run_op(1'b0, 3'b100, 32'h001, 32'h0, 5'd6, 32'h123480FF, 0, 1, 0);
    run_op(1'b0, 3'b000, 32'h003, 32'h0, 5'd7, 32'h80FFFFFF, 0, 0, 0);
    chk("lb_wb_lit", 64'(last_wb), 64'hFFFFFF80);

    run_op(1'b1, 3'b001, 32'h006, 32'h12345678, 5'd0, 32'h0, 0, 0, 0);
    chk("sh_be_lit", 64'(last_be), 64'hC);
    chk("sh_wdata_lit", 64'(last_wdata), 64'h56780000);

    run_op(1'b1, 3'b010, 32'h008, 32'hCAFEBABE, 5'd0, 32'h0, 3, 1, 0);
    run_op(1'b0, 3'b011, 32'h010, 32'h0, 5'd8, 32'h0, 0, 0, 0);
    chk("ld32_exc_lit", 64'(last_exc), 64'h3);
    run_op(1'b1, 3'b011, 32'h010, 32'h1, 5'd0, 32'h0, 0, 0, 0);
    run_op(1'b1, 3'b001, 32'h005, 32'h1, 5'd0, 32'h0, 0, 0, 0);
    chk("sh_mis_lit", 64'(last_exc), 64'h2);
    run_op(1'b0, 3'b110, 32'h000, 32'h0, 5'd8, 32'h0, 0, 0, 0);

    run_op(1'b0, 3'b010, 32'h020, 32'h0, 5'd9, 32'h0, 2, 0, 1);
    run_op(1'b0, 3'b010, 32'h024, 32'h0, 5'd9, 32'h0, 0, 0, 3);
    wb_before = wb_cnt;
    run_op(1'b0, 3'b101, 32'h00A, 32'h0, 5'd10, 32'hBEEF0000, 1, 1, 4);
    chk("kill_gnt_no_wb", 64'(wb_cnt), 64'(wb_before));
    run_op(1'b0, 3'b101, 32'h00A, 32'h0, 5'd10, 32'hBEEF0000, 0, 0, 0);
    chk("lhu_wb_lit", 64'(last_wb), 64'h0000BEEF);

    // Reset while waiting for the response, then a stale response.
    $display("op reset-in-WAIT then stale rvalid");
    wb_before = wb_cnt;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40; req_rd = 5'd11;
    exp_stall = 1'b1;
    exp_we = 1'b0; exp_be = 4'hF; exp_addr = 32'h40; exp_wdata = 32'h0;
    @(posedge clk); #1;
    exp_req = 1'b1; mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0; exp_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; req_valid = 1'b0; exp_stall = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'h77777777;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wait_no_wb", 64'(wb_cnt), 64'(wb_before));
    chk("rst_wait_wb_data", 64'(wb_data), 64'h0);
    run_op(1'b0, 3'b100, 32'h041, 32'h0, 5'd12, 32'h0000C300, 0, 1, 0);
    chk("recover_lbu_lit", 64'(last_wb), 64'hC3);

    // 64-bit instance
    $display("op xlen64 lwu addr=4 rdata=ffffffff00000000");
    x_req_valid = 1'b1; x_req_we = 1'b0; x_req_funct3 = 3'b110; x_req_addr = 32'h4; x_req_rd = 5'd7;
    #1;
    chk("x_stall_accept", 64'(x_stall), 64'h1);
    @(posedge clk); #1;
    chk("x_mem_req", 64'(x_mem_req), 64'h1);
    chk("x_mem_be", 64'(x_mem_be), 64'hF0);
    chk("x_mem_addr", 64'(x_mem_addr), 64'h0);
    x_mem_gnt = 1'b1;
    @(posedge clk); #1;
    x_mem_gnt = 1'b0; x_mem_rvalid = 1'b1; x_mem_rdata = 64'hFFFFFFFF_00000000;
    #1;
    chk("x_stall_release", 64'(x_stall), 64'h0);
    @(posedge clk); #1;
    x_mem_rvalid = 1'b0; x_req_valid = 1'b0;
    chk("x_wb_valid", 64'(x_wb_valid), 64'h1);
    chk("x_wb_rd", 64'(x_wb_rd), 64'h7);
    chk("x_wb_data", x_wb_data, 64'h00000000_FFFFFFFF);
    @(posedge clk); #1;
    chk("x_wb_pulse_end", 64'(x_wb_valid), 64'h0);
    $display("op xlen64 ld addr=4 (misaligned)");
    x_req_valid = 1'b1; x_req_funct3 = 3'b011; x_req_addr = 32'h4;
    #1;
    chk("x_ld_mis_stall", 64'(x_stall), 64'h0);
    @(posedge clk); #1;
    x_req_valid = 1'b0;
    chk("x_ld_mis_valid", 64'(x_exc_valid), 64'h1);
    chk("x_ld_mis_code", 64'(x_exc_code), 64'h1);
    chk("x_ld_mis_noreq", 64'(x_mem_req), 64'h0);
    @(posedge clk); #1;

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
